// File: rtl/shift_reg_univ_if.sv
// Signal bundle for shift_reg_univ: control/data inputs driven by the master,
// registered stage contents and occupancy status returned by the slave.
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                     clr;
    logic [1:0]               mode;
    logic [WIDTH-1:0]         sin;
    logic                     sin_valid;
    logic [DEPTH*WIDTH-1:0]   pin;
    logic                     rotate;
    logic [DEPTH*WIDTH-1:0]   q;
    logic [DEPTH-1:0]         q_valid;
    logic [WIDTH-1:0]         sout_up;
    logic [WIDTH-1:0]         sout_down;
    logic [CW-1:0]            count;
    logic                     full;
    logic                     empty;

    modport master (
        output clr, mode, sin, sin_valid, pin, rotate,
        input  q, q_valid, sout_up, sout_down, count, full, empty
    );

    modport slave (
        input  clr, mode, sin, sin_valid, pin, rotate,
        output q, q_valid, sout_up, sout_down, count, full, empty
    );
endinterface

// File: rtl/shift_reg_univ.sv
// Universal DEPTH x WIDTH shift register with per-stage valid bits and registered occupancy.
// Optional macro SHIFT_REG_UNIV_ROTATE_EN enables rotate-in-place on shifts.
module shift_reg_univ #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_reg_univ_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    // Each stage carries its valid bit in the MSB so data and valid always move together.
    typedef logic [WIDTH:0] entry_t;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    entry_t [DEPTH-1:0] ent_q;
    entry_t [DEPTH-1:0] ent_d;
    logic   [CW-1:0]    count_q;
    logic   [CW-1:0]    count_d;
    logic               full_q;
    logic               empty_q;

    entry_t serial_in;
    entry_t up_fill;
    entry_t down_fill;
    logic   rot;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign rot = bus.rotate;
`else
    logic unused_rotate;
    assign unused_rotate = bus.rotate;
    assign rot           = 1'b0;
`endif

    assign serial_in = {bus.sin_valid, bus.sin};
    assign up_fill   = rot ? ent_q[DEPTH-1] : serial_in;
    assign down_fill = rot ? ent_q[0]       : serial_in;

    // An unknown mode yields X rather than silently picking a legal branch.
    function automatic entry_t pick_next(
        input logic       clr,
        input logic [1:0] mode,
        input entry_t     hold_v,
        input entry_t     up_v,
        input entry_t     down_v,
        input entry_t     load_v
    );
        entry_t res;
        if (clr) begin
            res = '0;
        end else begin
            case (mode)
                MODE_HOLD: res = hold_v;
                MODE_UP:   res = up_v;
                MODE_DOWN: res = down_v;
                MODE_LOAD: res = load_v;
                default:   res = 'x;
            endcase
        end
        return res;
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            entry_t up_src;
            entry_t down_src;

            if (gi == 0) begin : g_up_edge
                assign up_src = up_fill;
            end else begin : g_up_mid
                assign up_src = ent_q[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_down_edge
                assign down_src = down_fill;
            end else begin : g_down_mid
                assign down_src = ent_q[gi+1];
            end

            assign ent_d[gi] = pick_next(bus.clr, bus.mode, ent_q[gi], up_src, down_src,
                                         {1'b1, bus.pin[gi*WIDTH +: WIDTH]});

            assign bus.q[gi*WIDTH +: WIDTH] = ent_q[gi][WIDTH-1:0];
            assign bus.q_valid[gi]          = ent_q[gi][WIDTH];
        end
    endgenerate

    // Occupancy is derived from the next valid vector so it lands on the same edge.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(ent_d[i][WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign bus.sout_up   = ent_q[DEPTH-1][WIDTH-1:0];
    assign bus.sout_down = ent_q[0][WIDTH-1:0];
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed and randomized checks of shift_reg_univ against an array-based reference model.
module tb_shift_reg_univ;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk;
    logic rst_n;

    shift_reg_univ_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    shift_reg_univ #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference state: one data word and one valid flag per stage.
    logic [WIDTH-1:0] m_data [DEPTH];
    bit               m_valid[DEPTH];

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i]  = '0;
            m_valid[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] d_in;
        bit               v_in;
        if (!rst_n || bus.clr) begin
            model_reset();
        end else if (bus.mode == 2'b01) begin
            d_in = (ROT_EN && bus.rotate) ? m_data[DEPTH-1]  : bus.sin;
            v_in = (ROT_EN && bus.rotate) ? m_valid[DEPTH-1] : bus.sin_valid;
            for (int i = DEPTH - 1; i > 0; i--) begin
                m_data[i]  = m_data[i-1];
                m_valid[i] = m_valid[i-1];
            end
            m_data[0]  = d_in;
            m_valid[0] = v_in;
        end else if (bus.mode == 2'b10) begin
            d_in = (ROT_EN && bus.rotate) ? m_data[0]  : bus.sin;
            v_in = (ROT_EN && bus.rotate) ? m_valid[0] : bus.sin_valid;
            for (int i = 0; i < DEPTH - 1; i++) begin
                m_data[i]  = m_data[i+1];
                m_valid[i] = m_valid[i+1];
            end
            m_data[DEPTH-1]  = d_in;
            m_valid[DEPTH-1] = v_in;
        end else if (bus.mode == 2'b11) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i]  = bus.pin[i*WIDTH +: WIDTH];
                m_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [DEPTH*WIDTH-1:0] exp_q;
        logic [DEPTH-1:0]       exp_v;
        int                     n;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q[i*WIDTH +: WIDTH] = m_data[i];
            exp_v[i]                = m_valid[i];
            n += int'(m_valid[i]);
        end
        chk({tag, ".q"},         64'(bus.q),         64'(exp_q));
        chk({tag, ".q_valid"},   64'(bus.q_valid),   64'(exp_v));
        chk({tag, ".count"},     64'(bus.count),     64'(n));
        chk({tag, ".full"},      64'(bus.full),      64'(n == DEPTH));
        chk({tag, ".empty"},     64'(bus.empty),     64'(n == 0));
        chk({tag, ".sout_up"},   64'(bus.sout_up),   64'(m_data[DEPTH-1]));
        chk({tag, ".sout_down"}, 64'(bus.sout_down), 64'(m_data[0]));
        $display("[TB] %s rst_n=%0b clr=%0b mode=%0d q=%h v=%b count=%0d",
                 tag, rst_n, bus.clr, bus.mode, bus.q, bus.q_valid, bus.count);
    endtask

    // One clock edge: model follows the inputs sampled at the edge, outputs checked 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic c, input logic [1:0] m, input logic [WIDTH-1:0] s,
                         input logic sv, input logic [DEPTH*WIDTH-1:0] p, input logic r);
        bus.clr       = c;
        bus.mode      = m;
        bus.sin       = s;
        bus.sin_valid = sv;
        bus.pin       = p;
        bus.rotate    = r;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, '0, 1'b0, '0, 1'b0);
        model_reset();

        // Reset held for two edges, then release and hold.
        step("rst0");
        step("rst1");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("hold");

        // Shift-up fill.
        drive(1'b0, 2'b01, 8'h11, 1'b1, '0, 1'b0); step("up11");
        drive(1'b0, 2'b01, 8'h22, 1'b1, '0, 1'b0); step("up22");
        drive(1'b0, 2'b01, 8'h33, 1'b1, '0, 1'b0); step("up33");
        drive(1'b0, 2'b01, 8'h44, 1'b1, '0, 1'b0); step("up44");
        chk("fill.q_const",   64'(bus.q),       64'h11223344);
        chk("fill.full",      64'(bus.full),    64'd1);
        chk("fill.sout_up",   64'(bus.sout_up), 64'h11);
        drive(1'b0, 2'b01, WIDTH'($urandom), 1'b0, '0, 1'b0); step("up_inv");
        chk("fill.count3",    64'(bus.count),   64'd3);

        // Parallel load then shift down.
        drive(1'b0, 2'b11, 8'h99, 1'b0, 32'hDDCCBBAA, 1'b0); step("load");
        chk("load.q_const",   64'(bus.q),       64'hDDCCBBAA);
        chk("load.count",     64'(bus.count),   64'd4);
        drive(1'b0, 2'b10, 8'hEE, 1'b1, '0, 1'b0); step("down");
        chk("down.q_const",   64'(bus.q),         64'hEEDDCCBB);
        chk("down.sout_down", 64'(bus.sout_down), 64'hBB);

        // Clear has priority over load.
        drive(1'b1, 2'b11, '0, 1'b0, 32'h12345678, 1'b0); step("clr_load");
        chk("clr.q_const",    64'(bus.q),     64'h0);
        chk("clr.empty",      64'(bus.empty), 64'd1);

        // Rotate vs plain shift with sin=0, sin_valid=0.
        drive(1'b0, 2'b11, '0, 1'b0, 32'h44332211, 1'b0); step("load_rot");
        drive(1'b0, 2'b01, '0, 1'b0, '0, 1'b1); step("rot_up");
        chk("rot.q_const",    64'(bus.q),     ROT_EN ? 64'h33221144 : 64'h33221100);
        chk("rot.count",      64'(bus.count), ROT_EN ? 64'd4 : 64'd3);
        drive(1'b0, 2'b10, 8'h5A, 1'b1, '0, 1'b1); step("rot_down");

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            drive(($urandom_range(0, 15) == 0), 2'($urandom), WIDTH'($urandom), 1'($urandom),
                  (DEPTH*WIDTH)'($urandom), 1'($urandom));
            step("rand");
        end

        // Asynchronous reset between edges while shifting.
        drive(1'b0, 2'b11, '0, 1'b0, 32'hA1B2C3D4, 1'b0); step("pre_async_load");
        drive(1'b0, 2'b01, 8'h77, 1'b1, '0, 1'b0); step("pre_async_up");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_now");
        step("async_edge");
        #2 rst_n = 1'b1;
        step("async_release");
        chk("release.q_const", 64'(bus.q), 64'h77);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
